// File: rtl/alu8_host_driver.sv
// ---------------------------------------------------------------------------
// alu8_host_driver
//   Host-side sequencer for an 8-bit ALU that has a single shared input bus.
//   It accepts one request (A, B, command, keep), loads the ALU over the
//   shared bus, waits for Done_i, and collects two result bytes: the low
//   byte, then the high byte or flags. The result is returned on a
//   valid/ready response channel. If Done_i never arrives, the response is
//   an error.
//
//   Handshake rules:
//     - Request: the transfer happens on a rising edge where both req_valid
//       and req_ready are 1.
//     - Response: the transfer happens on a rising edge where both rsp_valid
//       and rsp_ready are 1.
//     - rsp_valid only falls after the response transfer, and rsp_lo,
//       rsp_hi and rsp_err stay stable for as long as rsp_valid is 1.
//
//   The ALU registers each load strobe and captures the bus one cycle
//   later. That is why the bus carries A during STB, B during STC, and the
//   command from CMD onwards.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_a/req_b/req_cmd/req_keep  operands, command {MUL,BCD,shr,CI,op[3:0]}, reuse flag
//   ABCmd_o                       shared data bus to the ALU
//   LoadA_o/LoadB_o/LoadCmd_o     ALU load strobes
//   ACC_i, Done_i                 ALU result bus and done flag
//   rsp_valid/rsp_ready           response handshake
//   rsp_lo/rsp_hi/rsp_err         result low byte, high byte/flags, timeout flag
//   state_o                       current FSM state (debug)
// ---------------------------------------------------------------------------
module alu8_host_driver #(
   parameter int TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic [7:0] req_cmd,
   input  logic       req_keep,
   output logic [7:0] ABCmd_o,
   output logic       LoadA_o,
   output logic       LoadB_o,
   output logic       LoadCmd_o,
   input  logic [7:0] ACC_i,
   input  logic       Done_i,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_lo,
   output logic [7:0] rsp_hi,
   output logic       rsp_err,
   output logic [2:0] state_o
);

   // The counter width is sized so that it can hold TIMEOUT itself, so it never wraps.
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_STA  = 3'd1;
   localparam logic [2:0] S_STB  = 3'd2;
   localparam logic [2:0] S_STC  = 3'd3;
   localparam logic [2:0] S_CMD  = 3'd4;
   localparam logic [2:0] S_WAIT = 3'd5;
   localparam logic [2:0] S_FLAG = 3'd6;
   localparam logic [2:0] S_RESP = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [7:0]    a_q, a_d;
   logic [7:0]    b_q, b_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          keep_q, keep_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [7:0]    lo_q, lo_d;
   logic [7:0]    hi_q, hi_d;
   logic          err_q, err_d;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cmd_d   = cmd_q;
      keep_d  = keep_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               cmd_d   = req_cmd;
               keep_d  = req_keep;
               // With keep set, the ALU already holds the operands, so only the command is loaded.
               state_d = req_keep ? S_STC : S_STA;
            end
         end
         S_STA: state_d = S_STB;
         S_STB: state_d = S_STC;
         S_STC: state_d = S_CMD;
         S_CMD: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (Done_i) begin
               lo_d    = ACC_i;
               state_d = S_FLAG;
            end else if (cnt_inc == TMO) begin
               cnt_d   = cnt_inc;
               lo_d    = 8'h00;
               hi_d    = 8'h00;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_FLAG: begin
            // The command is still on the bus, so ACC_i now carries the high byte or flags.
            hi_d    = ACC_i;
            err_d   = 1'b0;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         cmd_q   <= 8'h00;
         keep_q  <= 1'b0;
         cnt_q   <= '0;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cmd_q   <= cmd_d;
         keep_q  <= keep_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
      end
   end

   // Moore outputs: these decode only from the current state and the latched request.
   always_comb begin
      ABCmd_o   = 8'h00;
      LoadA_o   = 1'b0;
      LoadB_o   = 1'b0;
      LoadCmd_o = 1'b0;
      case (state_q)
         S_STA: begin
            LoadA_o = 1'b1;
            ABCmd_o = a_q;
         end
         S_STB: begin
            LoadB_o = 1'b1;
            ABCmd_o = a_q;
         end
         S_STC: begin
            LoadCmd_o = 1'b1;
            ABCmd_o   = keep_q ? 8'h00 : b_q;
         end
         S_CMD, S_WAIT, S_FLAG: ABCmd_o = cmd_q;
         default: ABCmd_o = 8'h00;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_lo    = lo_q;
   assign rsp_hi    = hi_q;
   assign rsp_err   = err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_alu8_host_driver.sv
// ---------------------------------------------------------------------------
// tb_alu8_host_driver
//   Directed test bench with a small random section for alu8_host_driver.
//   It includes a behavioural ALU that registers each strobe and captures
//   the bus one cycle later. The ALU raises Done in the first cycle after
//   it captures the command, and returns the high byte or flags in the
//   following cycle. Expected responses are queued when a request is
//   driven, and are compared when the response appears.
// ---------------------------------------------------------------------------
module tb_alu8_host_driver;
   localparam int TIMEOUT = 4;
   localparam logic [2:0] S_WAIT = 3'd5;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_a, req_b, req_cmd;
   logic       req_keep;
   logic [7:0] ABCmd_o;
   logic       LoadA_o, LoadB_o, LoadCmd_o;
   logic [7:0] ACC_i;
   logic       Done_i;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_lo, rsp_hi;
   logic       rsp_err;
   logic [2:0] state_o;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [16:0] exp_q[$];

   alu8_host_driver #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd), .req_keep(req_keep),
      .ABCmd_o(ABCmd_o), .LoadA_o(LoadA_o), .LoadB_o(LoadB_o), .LoadCmd_o(LoadCmd_o),
      .ACC_i(ACC_i), .Done_i(Done_i),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
      .state_o(state_o)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural ALU ----------------
   logic       ld_a_q = 1'b0, ld_b_q = 1'b0, ld_c_q = 1'b0;
   logic [7:0] alu_a = 8'h00, alu_b = 8'h00, alu_cmd = 8'h00;
   int         alu_age = 99;
   bit         done_en = 1'b1;
   bit         stray_done = 1'b0;
   logic [15:0] prod;
   logic [8:0]  sum;
   logic [7:0]  alu_lo, alu_hi;

   always @(posedge clk) begin
      ld_a_q <= LoadA_o;
      ld_b_q <= LoadB_o;
      ld_c_q <= LoadCmd_o;
      if (ld_a_q) alu_a <= ABCmd_o;
      if (ld_b_q) alu_b <= ABCmd_o;
      if (ld_c_q) begin
         alu_cmd <= ABCmd_o;
         alu_age <= 0;
      end else if (alu_age < 99) begin
         alu_age <= alu_age + 1;
      end
   end

   always_comb begin
      prod = {8'h00, alu_a} * {8'h00, alu_b};
      sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cmd[4]};
      if (alu_cmd[7]) begin
         alu_lo = prod[7:0];
         alu_hi = prod[15:8];
      end else begin
         alu_lo = sum[7:0];
         alu_hi = {3'b000, sum[8], 1'b0, (sum[7:0] == 8'h00), sum[7], 1'b0};
      end
      ACC_i  = (alu_age == 0) ? alu_lo : alu_hi;
      Done_i = (done_en && (alu_age == 0)) || stray_done;
   end

   // ---------------- reference result ----------------
   function automatic logic [16:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] cmd);
      logic [15:0] p;
      logic [8:0]  s;
      p = {8'h00, a} * {8'h00, b};
      s = {1'b0, a} + {1'b0, b} + {8'h00, cmd[4]};
      if (cmd[7]) return {1'b0, p[15:8], p[7:0]};
      return {1'b0, 3'b000, s[8], 1'b0, (s[7:0] == 8'h00), s[7], 1'b0, s[7:0]};
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver: one full transaction ----------------
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cmd,
                          input logic keep, input logic [16:0] exp, input int exp_lat,
                          input int hold);
      int n, off, na, nb, nc, sa, sb, sc;
      bit got;
      logic [16:0] obs, e;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_a = a; req_b = b; req_cmd = cmd; req_keep = keep; req_valid = 1'b1;
      n = cyc;
      exp_q.push_back(exp);
      na = 0; nb = 0; nc = 0; sa = -1; sb = -1; sc = -1;
      @(negedge clk);
      req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         off = cyc - n;
         if (rsp_valid) begin
            got = 1'b1;
         end else begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (LoadA_o) begin na++; sa = off; chk("bus_sta", 32'(ABCmd_o), 32'(a)); end
            if (LoadB_o) begin nb++; sb = off; chk("bus_stb", 32'(ABCmd_o), 32'(a)); end
            if (LoadCmd_o) begin
               nc++; sc = off;
               chk("bus_stc", 32'(ABCmd_o), keep ? 32'd0 : 32'(b));
            end
            if (off >= (keep ? 2 : 4)) chk("bus_cmd", 32'(ABCmd_o), 32'(cmd));
            @(negedge clk);
         end
      end
      chk("rsp_seen", 32'(got), 32'd1);
      chk("latency", cyc - n, exp_lat);
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
      obs = {rsp_err, rsp_hi, rsp_lo};
      chk("rsp_data", 32'(obs), 32'(e));
      chk("bus_resp", 32'(ABCmd_o), 32'd0);
      if (keep) begin
         chk("loada_cnt_keep", na, 0);
         chk("loadb_cnt_keep", nb, 0);
         chk("loadc_off_keep", sc, 1);
      end else begin
         chk("loada_off", sa, 1);
         chk("loadb_off", sb, 2);
         chk("loadc_off", sc, 3);
         chk("loada_cnt", na, 1);
         chk("loadb_cnt", nb, 1);
      end
      chk("loadc_cnt", nc, 1);
      // Hold the response under backpressure; a stray Done must change nothing.
      if (hold > 0) stray_done = 1'b1;
      for (int j = 0; j < hold; j++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data", 32'({rsp_err, rsp_hi, rsp_lo}), 32'(obs));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      stray_done = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
      rsp_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      logic [7:0] la, lb, ra, rb, rc;
      logic       rk;
      int n;
      reset = 1'b1; req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_cmd = 8'h00;
      req_keep = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_bus", 32'(ABCmd_o), 32'd0);
      chk("rst_strobes", 32'({LoadA_o, LoadB_o, LoadCmd_o}), 32'd0);
      chk("rst_rsp", 32'({rsp_err, rsp_hi, rsp_lo}), 32'd0);
      reset = 1'b0;

      // MUL 0xFF*0xFF, full load: result 0xFE01 in cycle n+7.
      run_txn(8'hFF, 8'hFF, 8'h80, 1'b0, {1'b0, 8'hFE, 8'h01}, 7, 0);
      // Same command, reusing the operands: n+5, no A/B loads.
      run_txn(8'h00, 8'h00, 8'h80, 1'b1, {1'b0, 8'hFE, 8'h01}, 5, 0);
      // Add with carry-in, then backpressure for 10 cycles.
      run_txn(8'hC3, 8'h5A, 8'h10, 1'b0, alu_ref(8'hC3, 8'h5A, 8'h10), 7, 10);
      la = 8'hC3; lb = 8'h5A;

      // Timeout: Done never comes; 4 WAIT cycles then error response (n+9).
      done_en = 1'b0;
      run_txn(8'h12, 8'h34, 8'h80, 1'b0, {1'b1, 8'h00, 8'h00}, 5 + TIMEOUT, 0);
      done_en = 1'b1;
      // The next good response must clear the error flag.
      run_txn(8'h07, 8'h09, 8'h80, 1'b0, alu_ref(8'h07, 8'h09, 8'h80), 7, 0);
      la = 8'h07; lb = 8'h09;

      // Reset while in WAIT: the transaction is abandoned with no response.
      done_en = 1'b0;
      @(negedge clk);
      req_a = 8'h22; req_b = 8'h33; req_cmd = 8'h80; req_keep = 1'b0; req_valid = 1'b1;
      n = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 20 && cyc < n + 6; i++) @(negedge clk);
      chk("in_wait", 32'(state_o), 32'(S_WAIT));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rw_req_ready", 32'(req_ready), 32'd1);
      chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rw_bus", 32'(ABCmd_o), 32'd0);
      chk("rw_strobes", 32'({LoadA_o, LoadB_o, LoadCmd_o}), 32'd0);
      chk("rw_rsp", 32'({rsp_err, rsp_hi, rsp_lo}), 32'd0);
      done_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
      end
      run_txn(8'h10, 8'h20, 8'h80, 1'b0, alu_ref(8'h10, 8'h20, 8'h80), 7, 0);
      la = 8'h10; lb = 8'h20;

      // Random mix of MUL/ADD, with and without keep.
      for (int t = 0; t < 8; t++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'($urandom_range(0, 1) << 4);
         rk = 1'($urandom_range(0, 2) == 0);
         if (rk) begin
            run_txn(ra, rb, rc, 1'b1, alu_ref(la, lb, rc), 5, $urandom_range(0, 2));
         end else begin
            run_txn(ra, rb, rc, 1'b0, alu_ref(ra, rb, rc), 7, $urandom_range(0, 2));
            la = ra; lb = rb;
         end
      end

      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu8_host_driver.md
ALU8_HOST_DRIVER -- requirements
Module: alu8_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4, meaning the maximum cycles spent waiting for Done_i before an error response.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-006 SHALL have ports req_a / req_b / req_cmd  input  8 each  operand A, operand B, ALU command {MUL, BCD, shr, CI, op[3:0]}.
REQ-007 SHALL have port req_keep  input  1  skip the A/B loads and reuse operands already held by the ALU.
REQ-008 SHALL have ports ABCmd_o  output  8  shared data bus to the ALU; LoadA_o / LoadB_o / LoadCmd_o  output  1 each  load strobes.
REQ-009 SHALL have ports ACC_i  input  8  ALU result bus; Done_i  input  1  ALU done flag.
REQ-010 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_lo / rsp_hi  output  8 each  result low byte and high byte/flags; rsp_err  output  1  timeout indicator.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, STA, STB, STC, CMD, WAIT, FLAG, RESP; all bus outputs decode from state only.
REQ-012 IDLE: req_ready=1; on req_valid, latch req_a/b/cmd/keep, then go to STA (keep=0) or STC (keep=1); otherwise stay.
REQ-013 Strobes per state: STA LoadA_o=1; STB LoadB_o=1; STC LoadCmd_o=1; every other state, all strobes 0.
REQ-014 ABCmd_o per state: IDLE 0x00; STA A; STB A; STC B (B if keep=0, 0x00 if keep=1); CMD, WAIT, FLAG latched cmd; RESP 0x00.
REQ-015 Cmd SHALL stay on ABCmd_o from CMD through FLAG, so the ALU evaluates the same command for both the low-byte and the flag/high-byte phases.
REQ-016 Transitions: STA->STB->STC->CMD->WAIT are unconditional, one cycle each.
REQ-017 WAIT: if Done_i=1, capture ACC_i into rsp_lo and go to FLAG; otherwise increment the wait counter.
REQ-018 WAIT timeout: when the counter reaches TIMEOUT without Done_i, go to RESP with rsp_err=1 and rsp_lo=rsp_hi=0x00.
REQ-019 FLAG: capture ACC_i into rsp_hi and clear rsp_err; go to RESP. The captured byte is the product high byte when MUL=1, and {000,CO,V,Z,N,HC} otherwise.
REQ-020 RESP: rsp_valid=1 with rsp_lo/hi/err held stable until rsp_ready=1, then go to IDLE; rsp_valid is never high in any other state.
REQ-021 req_ready SHALL be 0 in every state except IDLE; no new request is accepted while RESP is pending.
REQ-022 Latency: for a request accepted in cycle n, rsp_valid rises in cycle n+7 (keep=0) or n+5 (keep=1), given Done_i arrives in the first WAIT cycle.
REQ-023 Wait counter: at least clog2(TIMEOUT+1) bits; cleared on entry to WAIT; never wraps.
REQ-024 Back-to-back requests: the earliest next accept is the cycle after the RESP handshake.
REQ-025 Done_i seen outside WAIT SHALL be ignored; ACC_i is sampled only in WAIT (on Done_i) and in FLAG.

Reset
REQ-026 While reset=1 at a clock edge: state=IDLE; strobes=0; ABCmd_o=0x00; rsp_valid=0; rsp_lo=rsp_hi=0x00; rsp_err=0; wait counter=0; latched operands=0.
REQ-027 Reset asserted mid-operation SHALL abandon the transaction with no response; req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-028 MUL: A=0xFF, B=0xFF, cmd=0x80, keep=0, paired with an ALU behavioural model -> bus trace STA/STB/STC strobes in consecutive cycles; rsp_lo=0x01, rsp_hi=0xFE, rsp_err=0 in cycle n+7.
REQ-029 Keep: after the previous transaction, cmd=0x80, keep=1 -> no LoadA_o or LoadB_o pulse; rsp_lo=0x01, rsp_hi=0xFE in cycle n+5.
REQ-030 Timeout: Done_i tied 0 with TIMEOUT=4 -> exactly 4 WAIT cycles, then rsp_valid=1, rsp_err=1, rsp_lo=rsp_hi=0x00.
REQ-031 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp data stable and req_ready=0 throughout; on rsp_ready=1, IDLE next cycle.
REQ-032 Reset in WAIT: reset=1 for one cycle -> all outputs take their REQ-026 values, no rsp_valid pulse, and the next request completes normally.
